// File: rtl/mux_sel_serializer.sv
// Byte serializer: latches a word on handshake and drives one bit per cycle via an 8:1 mux select.
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module mux_sel_serializer #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic       i_msb_first,
   output logic [2:0] o_sel,
   output logic       o_serial,
   output logic       o_bit_valid,
   output logic       o_frame_start,
   output logic       o_frame_end,
   output logic       o_busy
);

   // state  | meaning
   // IDLE   | no frame in progress, ready for a word
   // SHIFT  | driving data bits, o_sel walks 7..0 or 0..7
   // PARITY | driving the even-parity bit, o_sel held (SER_PARITY_EN only)
`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t     state;
   logic [7:0] word;
   logic       msb_first;
   logic [2:0] bit_cnt;
   logic       accept;
   logic [2:0] load_sel;
   logic [2:0] next_sel;

   assign accept   = i_valid & o_ready;
   assign load_sel = i_msb_first ? 3'd7 : 3'd0;
   assign next_sel = msb_first ? o_sel - 3'd1 : o_sel + 3'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         word          <= 8'h00;
         msb_first     <= 1'b0;
         bit_cnt       <= 3'd0;
         o_ready       <= 1'b1;
         o_sel         <= 3'd0;
         o_serial      <= IDLE_LEVEL;
         o_bit_valid   <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_end   <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_frame_start <= 1'b0;
         o_frame_end   <= 1'b0;
         // accept is only possible in IDLE or the final cycle of a frame
         if (accept) begin
            state         <= SHIFT;
            word          <= i_data;
            msb_first     <= i_msb_first;
            bit_cnt       <= 3'd7;
            o_sel         <= load_sel;
            o_serial      <= i_data[load_sel];
            o_bit_valid   <= 1'b1;
            o_frame_start <= 1'b1;
            o_busy        <= 1'b1;
            o_ready       <= 1'b0;
         end else begin
            case (state)
               SHIFT: begin
                  if (bit_cnt != 3'd0) begin
                     bit_cnt  <= bit_cnt - 3'd1;
                     o_sel    <= next_sel;
                     o_serial <= word[next_sel];
`ifndef SER_PARITY_EN
                     if (bit_cnt == 3'd1) begin
                        o_ready     <= 1'b1;
                        o_frame_end <= 1'b1;
                     end
`endif
                  end else begin
`ifdef SER_PARITY_EN
                     state       <= PARITY;
                     o_serial    <= ^word;
                     o_ready     <= 1'b1;
                     o_frame_end <= 1'b1;
`else
                     state       <= IDLE;
                     o_ready     <= 1'b1;
                     o_sel       <= 3'd0;
                     o_serial    <= IDLE_LEVEL;
                     o_bit_valid <= 1'b0;
                     o_busy      <= 1'b0;
`endif
                  end
               end
`ifdef SER_PARITY_EN
               PARITY: begin
                  state       <= IDLE;
                  o_ready     <= 1'b1;
                  o_sel       <= 3'd0;
                  o_serial    <= IDLE_LEVEL;
                  o_bit_valid <= 1'b0;
                  o_busy      <= 1'b0;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
